// File: rtl/sysbus_arbiter.sv
// Two-client (icache/dcache) system bus arbiter with owner-only request mux and response routing.
// Latency: busgrant one registered cycle after busreq is sampled in IDLE; bus mux is combinational from state.
// Backpressure: losers wait in their own bus FSMs; SYSBUS_ARB_DCACHE_PRIO_EN makes dcache win ties.
module sysbus_arbiter #(
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int GRANT_TIMEOUT  = 4
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      icache_busreq,
    input  logic                      icache_busidle,
    output logic                      icache_busgrant,
    input  logic                      icache_bus_reqcyc,
    input  logic                      icache_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] icache_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  icache_bus_reqtag,
    output logic                      icache_bus_respcyc,
    output logic                      icache_bus_reqack,

    input  logic                      dcache_busreq,
    input  logic                      dcache_busidle,
    output logic                      dcache_busgrant,
    input  logic                      dcache_bus_reqcyc,
    input  logic                      dcache_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] dcache_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  dcache_bus_reqtag,
    output logic                      dcache_bus_respcyc,
    output logic                      dcache_bus_reqack,

    output logic                      bus_reqcyc,
    output logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    input  logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,

    output logic [BUS_DATA_WIDTH-1:0] resp_data,
    output logic [BUS_TAG_WIDTH-1:0]  resp_tag
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_BUSY    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [7:0] TIMEOUT_LAST = 8'(GRANT_TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;
    logic [7:0] cnt_q, cnt_d;

    logic       arb_pick;
    logic       owner_busidle;
    logic       active;
    logic       sel_i;
    logic       sel_d;

    // Owner encoding: 0 = icache, 1 = dcache.
    always_comb begin
        arb_pick = 1'b0;
`ifdef SYSBUS_ARB_DCACHE_PRIO_EN
        arb_pick = dcache_busreq;
`else
        if (icache_busreq && dcache_busreq) begin
            arb_pick = ~last_owner_q;
        end else begin
            arb_pick = dcache_busreq;
        end
`endif
    end

    assign owner_busidle = owner_q ? dcache_busidle : icache_busidle;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (icache_busreq || dcache_busreq) begin
                    state_d = ST_GRANT;
                    owner_d = arb_pick;
                    cnt_d   = 8'd0;
                end
            end
            ST_GRANT: begin
                // A granted client that never leaves idle has withdrawn its request.
                if (!owner_busidle) begin
                    state_d = ST_BUSY;
                    cnt_d   = 8'd0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_BUSY: begin
                if (owner_busidle) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cnt_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
        end
    end

    // Everything below is decoded from registered state, so IDLE/RELEASE force all gated paths to zero.
    assign active = (state_q == ST_GRANT) || (state_q == ST_BUSY);
    assign sel_i  = active && !owner_q;
    assign sel_d  = active && owner_q;

    assign icache_busgrant = sel_i;
    assign dcache_busgrant = sel_d;

    assign bus_reqcyc  = (sel_i & icache_bus_reqcyc)  | (sel_d & dcache_bus_reqcyc);
    assign bus_respack = (sel_i & icache_bus_respack) | (sel_d & dcache_bus_respack);
    assign bus_req     = ({BUS_DATA_WIDTH{sel_i}} & icache_bus_req)
                       | ({BUS_DATA_WIDTH{sel_d}} & dcache_bus_req);
    assign bus_reqtag  = ({BUS_TAG_WIDTH{sel_i}} & icache_bus_reqtag)
                       | ({BUS_TAG_WIDTH{sel_d}} & dcache_bus_reqtag);

    assign icache_bus_respcyc = sel_i & bus_respcyc;
    assign icache_bus_reqack  = sel_i & bus_reqack;
    assign dcache_bus_respcyc = sel_d & bus_respcyc;
    assign dcache_bus_reqack  = sel_d & bus_reqack;

    assign resp_data = bus_resp;
    assign resp_tag  = bus_resptag;

endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache, between them and the single system bus.
- Arbitrates each cache's busreq/busidle/busgrant handshake and grants bus ownership to exactly one cache at a time.
- Muxes the owner's request-side bus signals onto the system bus.
- Routes the bus's response-side handshake back to the owner only.

Parameters:
- BUS_TAG_WIDTH, 13, width of bus_reqtag/bus_resptag.
- BUS_DATA_WIDTH, 64, width of bus_req/bus_resp.
- GRANT_TIMEOUT, 4, cycles a granted client may stay busidle=1 before the grant is revoked (range 2..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- icache_busreq  in  1  icache requests ownership
- icache_busidle  in  1  icache bus FSM idle
- icache_busgrant  out  1  ownership granted to icache
- icache_bus_reqcyc / icache_bus_respack  in  1 each  icache request-side strobes
- icache_bus_req  in  BUS_DATA_WIDTH  icache request address/data
- icache_bus_reqtag  in  BUS_TAG_WIDTH  icache request tag
- icache_bus_respcyc / icache_bus_reqack  out  1 each  gated response strobes to icache
- dcache_busreq, dcache_busidle, dcache_busgrant, dcache_bus_reqcyc, dcache_bus_respack, dcache_bus_req, dcache_bus_reqtag, dcache_bus_respcyc, dcache_bus_reqack: same as the icache ports, for dcache
- bus_reqcyc / bus_respack  out  1 each  to system bus
- bus_req  out  BUS_DATA_WIDTH  to system bus
- bus_reqtag  out  BUS_TAG_WIDTH  to system bus
- bus_respcyc / bus_reqack  in  1 each  from system bus
- bus_resp  in  BUS_DATA_WIDTH  from system bus
- bus_resptag  in  BUS_TAG_WIDTH  from system bus
- resp_data  out  BUS_DATA_WIDTH  bus_resp broadcast to both caches
- resp_tag  out  BUS_TAG_WIDTH  bus_resptag broadcast to both caches

Behaviour:
- Single clock, clk. Synchronous active-high reset.
- State register: state ∈ {IDLE, GRANT, BUSY, RELEASE}, plus owner (0=icache, 1=dcache) and last_owner.
- Reset values: state=IDLE, owner=0, last_owner=1 (icache wins the first tie), timeout counter=0, both busgrant=0.
  - All bus request-side outputs read 0 and both gated response strobes read 0 from the first cycle after the reset edge.
- IDLE:
  - If exactly one busreq=1, that client becomes owner.
  - If both, owner = !last_owner (round-robin).
  - On a choice: go to GRANT, and the owner's busgrant goes 1 on the next edge (1-cycle registered latency).
  - If no busreq: stay in IDLE.
- GRANT:
  - Owner's busgrant=1. Counter increments each cycle.
  - Owner busidle=0 → BUSY, counter cleared.
  - Counter reaches GRANT_TIMEOUT with busidle still 1 → RELEASE (requester withdrew).
- BUSY:
  - busgrant held at 1.
  - Owner busidle returns to 1 → RELEASE.
  - No timeout applies in BUSY.
- RELEASE:
  - busgrant=0, bus outputs forced to 0 (one dead cycle).
  - last_owner<=owner; then → IDLE.
- Muxing is combinational from state/owner:
  - In GRANT or BUSY: bus_reqcyc/req/reqtag/respack = owner's signals; owner's respcyc/reqack = bus_respcyc/bus_reqack.
  - The non-owner's strobes are 0, and the non-owner's request-side inputs are ignored.
  - In IDLE or RELEASE: all bus request-side outputs are 0 and both gated strobes are 0.
- resp_data/resp_tag are always bus_resp/bus_resptag, ungated.
- Never more than one busgrant=1 in any cycle; busgrant is 0 in IDLE and RELEASE.
- A request arriving while the other client is GRANT/BUSY waits and is sampled in the next IDLE.
  - Minimum gap between two ownerships: 2 cycles (RELEASE + IDLE).
- busreq dropping during GRANT has no effect; only busidle and the timeout matter.
- Reset mid-BUSY: the next state is IDLE, grants 0, and bus outputs 0 at once. The system bus transaction is abandoned; the caches reset on the same reset.

Optional Feature:
- Macro: SYSBUS_ARB_DCACHE_PRIO_EN.
- Defined: simultaneous requests in IDLE always go to dcache; last_owner is unused for the choice.
- Undefined: round-robin as above.
- All other behaviour is identical either way.

Test Plan:
- Reset, then icache_busreq=1 only at cycle 0 → icache_busgrant=1 at cycle 1. Icache drives bus_reqcyc=1, bus_req=0x1000 → bus_req=0x1000. dcache_bus_respcyc stays 0 throughout.
- Both busreq=1 from reset → icache owns first. After icache busidle 0→1: RELEASE, then IDLE, and dcache_busgrant=1 three cycles after icache_busidle returns to 1. With SYSBUS_ARB_DCACHE_PRIO_EN defined, dcache owns first.
- Icache granted but busidle stays 1 → grant revoked after 4 cycles with GRANT_TIMEOUT=4. The pending dcache_busreq is granted 2 cycles later.
- During icache BUSY, bus_respcyc=1, bus_resp=0xDEADBEEF → icache_bus_respcyc=1 and resp_data=0xDEADBEEF. dcache_bus_respcyc=0. dcache_bus_reqcyc=1 does not reach bus_reqcyc.
- reset=1 while dcache is BUSY → next cycle both busgrant=0, bus_reqcyc=0, bus_respack=0, state IDLE. A later icache_busreq is granted normally.
- Randomised 10k cycles of both requesters → assert one-hot-or-zero grants, no bus_reqcyc outside GRANT/BUSY, and no requester starved beyond one opposing ownership.
